// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: final reordering stage of the 512-point FFT.
// Frames arrive as 32 beats of 16 lanes in bit-reversed index order. Each
// frame is captured into one of two register banks and then gathered out in
// natural frequency order. While one bank is read, the other bank fills, so
// frames can stream continuously with no stall.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 13,
    parameter int N          = 16,
    parameter int BLOCK_CNT  = 32,
    parameter bit BITREV_EN  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] din_i [0:N-1],
    input  logic signed [DATA_WIDTH-1:0] din_q [0:N-1],
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] dout_i [0:N-1],
    output logic signed [DATA_WIDTH-1:0] dout_q [0:N-1],
    output logic                         sof_out,
    output logic                         eof_out,
    output logic                         busy
);

    localparam int FRAME = N * BLOCK_CNT;
    localparam int AW    = $clog2(FRAME);
    localparam int BW    = $clog2(BLOCK_CNT);
    localparam int LW    = $clog2(N);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_CNT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

    // Reverse the bit order of a frame position.
    function automatic logic [AW-1:0] bitrev_addr(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = a[AW-1-b];
        end
        return r;
    endfunction

    // Sample storage: two banks, flat frame position = beat*N + lane.
    logic signed [DATA_WIDTH-1:0] mem_i_r [0:1][0:FRAME-1];
    logic signed [DATA_WIDTH-1:0] mem_q_r [0:1][0:FRAME-1];

    logic [BW-1:0] wcnt_r;
    logic          wbank_r;
    logic [1:0]    full_r;
    rd_state_t     state_r;
    logic          rbank_r;
    logic [BW-1:0] rcnt_r;

    logic          rd_go_s;
    logic          rd_bank_s;
    logic [BW-1:0] rd_beat_s;
    logic          rd_last_s;
    logic          wr_last_s;
    logic [1:0]    full_set_s;
    logic [1:0]    full_clr_s;
    logic          other_ready_s;
    logic [AW-1:0] gat_addr_s [0:N-1];
    logic signed [DATA_WIDTH-1:0] gat_i_s [0:N-1];
    logic signed [DATA_WIDTH-1:0] gat_q_s [0:N-1];

    // Pick the beat to emit this cycle: continue the current read, or start
    // beat 0 of the oldest full bank straight from idle (one-cycle latency).
    always_comb begin
        rd_go_s   = 1'b0;
        rd_bank_s = 1'b0;
        rd_beat_s = '0;
        if (state_r == ST_READ) begin
            rd_go_s   = 1'b1;
            rd_bank_s = rbank_r;
            rd_beat_s = rcnt_r;
        end else if (full_r != 2'b00) begin
            rd_go_s   = 1'b1;
            // With both banks full the older one is the bank about to be rewritten.
            rd_bank_s = (full_r == 2'b11) ? wbank_r : full_r[1];
            rd_beat_s = '0;
        end else begin
            rd_go_s   = 1'b0;
        end
    end

    // Frame boundary events on both sides and the back-to-back hand-over test.
    always_comb begin
        rd_last_s     = rd_go_s && (rd_beat_s == LAST_BEAT);
        wr_last_s     = valid_in && (wcnt_r == LAST_BEAT);
        full_set_s    = wr_last_s ? (wbank_r ? 2'b10 : 2'b01) : 2'b00;
        full_clr_s    = rd_last_s ? (rd_bank_s ? 2'b10 : 2'b01) : 2'b00;
        other_ready_s = rd_bank_s ? (full_r[0] | full_set_s[0])
                                  : (full_r[1] | full_set_s[1]);
    end

    // Gather one output beat: lane j of beat m is natural index m*N + j.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            gat_addr_s[j] = BITREV_EN ? bitrev_addr({rd_beat_s, LW'(j)})
                                      : {rd_beat_s, LW'(j)};
            gat_i_s[j]    = mem_i_r[rd_bank_s][gat_addr_s[j]];
            gat_q_s[j]    = mem_q_r[rd_bank_s][gat_addr_s[j]];
        end
    end

    // Capture incoming lanes into the bank being filled; contents need no reset.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int l = 0; l < N; l++) begin
                mem_i_r[wbank_r][{wcnt_r, LW'(l)}] <= din_i[l];
                mem_q_r[wbank_r][{wcnt_r, LW'(l)}] <= din_q[l];
            end
        end
    end

    // Write counter, bank flags, read FSM and registered output beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r    <= '0;
            wbank_r   <= 1'b0;
            full_r    <= 2'b00;
            state_r   <= ST_IDLE;
            rbank_r   <= 1'b0;
            rcnt_r    <= '0;
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            eof_out   <= 1'b0;
            for (int j = 0; j < N; j++) begin
                dout_i[j] <= '0;
                dout_q[j] <= '0;
            end
        end else begin
            if (valid_in) begin
                if (wr_last_s) begin
                    wcnt_r  <= '0;
                    wbank_r <= ~wbank_r;
                end else begin
                    wcnt_r  <= wcnt_r + BW'(1);
                end
            end else begin
                wcnt_r <= wcnt_r;
            end

            full_r <= (full_r & ~full_clr_s) | full_set_s;

            if (rd_go_s) begin
                if (rd_last_s) begin
                    rcnt_r <= '0;
                    if (other_ready_s) begin
                        state_r <= ST_READ;
                        rbank_r <= ~rd_bank_s;
                    end else begin
                        state_r <= ST_IDLE;
                        rbank_r <= rd_bank_s;
                    end
                end else begin
                    state_r <= ST_READ;
                    rbank_r <= rd_bank_s;
                    rcnt_r  <= rd_beat_s + BW'(1);
                end
            end else begin
                state_r <= ST_IDLE;
                rcnt_r  <= '0;
            end

            valid_out <= rd_go_s;
            sof_out   <= rd_go_s && (rd_beat_s == '0);
            eof_out   <= rd_last_s;
            for (int j = 0; j < N; j++) begin
                dout_i[j] <= rd_go_s ? gat_i_s[j] : '0;
                dout_q[j] <= rd_go_s ? gat_q_s[j] : '0;
            end
        end
    end

    assign busy = full_r[0] | full_r[1] | (wcnt_r != '0) | (state_r == ST_READ);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: one instance in bit-reverse mode and
// one in arrival-order mode share the same input stream.
module tb_fft_bitrev_reorder;

    localparam int DW = 13;
    localparam int N  = 16;
    localparam int BC = 32;
    localparam int PW = DW * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0;
    logic signed [DW-1:0] din_i [0:N-1];
    logic signed [DW-1:0] din_q [0:N-1];

    logic valid_out, sof_out, eof_out, busy;
    logic signed [DW-1:0] dout_i [0:N-1];
    logic signed [DW-1:0] dout_q [0:N-1];
    logic nr_valid_out, nr_sof_out, nr_eof_out, nr_busy;
    logic signed [DW-1:0] nr_dout_i [0:N-1];
    logic signed [DW-1:0] nr_dout_q [0:N-1];

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    int             oc_q[$], nc_q[$];
    logic [PW-1:0]  oi_q[$], oq_q[$], ni_q[$], nq_q[$];
    bit             os_q[$], oe_q[$], ns_q[$], ne_q[$];

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N(N), .BLOCK_CNT(BC), .BITREV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din_i(din_i), .din_q(din_q),
        .valid_out(valid_out), .dout_i(dout_i), .dout_q(dout_q),
        .sof_out(sof_out), .eof_out(eof_out), .busy(busy));

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N(N), .BLOCK_CNT(BC), .BITREV_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din_i(din_i), .din_q(din_q),
        .valid_out(nr_valid_out), .dout_i(nr_dout_i), .dout_q(nr_dout_q),
        .sof_out(nr_sof_out), .eof_out(nr_eof_out), .busy(nr_busy));

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [PW-1:0] pack(input logic signed [DW-1:0] a [0:N-1]);
        logic [PW-1:0] v;
        for (int l = 0; l < N; l++) v[l*DW +: DW] = a[l];
        return v;
    endfunction

    function automatic logic [8:0] br9(input logic [8:0] a);
        logic [8:0] r;
        for (int b = 0; b < 9; b++) r[b] = a[8-b];
        return r;
    endfunction

    // Input sample at frame position p. mode 0: bit-reversed ramp,
    // mode 1: natural ramp, mode 2: extreme values mixed with a ramp.
    function automatic logic signed [DW-1:0] in_i(input int f, input int p, input int mode);
        case (mode)
            0: return DW'(int'(br9(9'(p))) + f * 512);
            1: return DW'(p + f * 512);
            default: begin
                case (p % 4)
                    0: return 13'h0FFF;
                    1: return 13'h1000;
                    2: return DW'(p);
                    default: return DW'(-p);
                endcase
            end
        endcase
    endfunction

    function automatic logic signed [DW-1:0] in_q(input int f, input int p, input int mode);
        logic signed [DW-1:0] v;
        v = in_i(f, p, mode);
        return (mode == 2) ? ~v : -v;
    endfunction

    // Expected real sample at natural index k for the bit-reverse instance.
    function automatic logic signed [DW-1:0] exp_br(input int f, input int k, input int mode);
        if (mode == 0) return DW'(k + f * 512);
        else           return in_i(f, int'(br9(9'(k))), mode);
    endfunction

    // Expected real sample at output position k for the arrival-order instance.
    function automatic logic signed [DW-1:0] exp_nr(input int f, input int k, input int mode);
        if (mode == 1) return DW'(k + f * 512);
        else           return in_i(f, k, mode);
    endfunction

    always @(negedge clk) begin
        if (valid_out) begin
            oc_q.push_back(edge_cnt); oi_q.push_back(pack(dout_i)); oq_q.push_back(pack(dout_q));
            os_q.push_back(sof_out);  oe_q.push_back(eof_out);
        end
        if (nr_valid_out) begin
            nc_q.push_back(edge_cnt); ni_q.push_back(pack(nr_dout_i)); nq_q.push_back(pack(nr_dout_q));
            ns_q.push_back(nr_sof_out); ne_q.push_back(nr_eof_out);
        end
    end

    task automatic clear_queues();
        oc_q.delete(); oi_q.delete(); oq_q.delete(); os_q.delete(); oe_q.delete();
        nc_q.delete(); ni_q.delete(); nq_q.delete(); ns_q.delete(); ne_q.delete();
    endtask

    task automatic drive_beat(input logic [PW-1:0] vi, input logic [PW-1:0] vq, input logic v);
        @(posedge clk);
        #1;
        valid_in = v;
        for (int l = 0; l < N; l++) begin
            din_i[l] = vi[l*DW +: DW];
            din_q[l] = vq[l*DW +: DW];
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({valid_out, sof_out, eof_out, busy, nr_valid_out, nr_busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {valid_out, sof_out, eof_out, busy, nr_valid_out, nr_busy});
        end
        n_cmp++;
        if (pack(dout_i) !== '0 || pack(dout_q) !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h / %h want 0", pack(dout_i), pack(dout_q));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive nf frames (optionally with a one-cycle gap after every beat) and
    // check order, timing, framing flags and count on both instances.
    task automatic test_stream(input string name, input int nf, input int mode, input bit gapped);
        logic [PW-1:0] vi, vq, e_bi, e_bq, e_ni, e_nq;
        int first, tot, f, m, k;
        clear_queues();
        first = 0;
        for (int fr = 0; fr < nf; fr++) begin
            for (int b = 0; b < BC; b++) begin
                for (int l = 0; l < N; l++) begin
                    vi[l*DW +: DW] = in_i(fr, b*N + l, mode);
                    vq[l*DW +: DW] = in_q(fr, b*N + l, mode);
                end
                drive_beat(vi, vq, 1'b1);
                if (fr == 0 && b == BC - 1) first = edge_cnt + 2;
                if (gapped) drive_beat('0, '0, 1'b0);
            end
        end
        drive_beat('0, '0, 1'b0);
        tot = nf * BC;
        for (int w = 0; w < 200 && (oi_q.size() < tot || ni_q.size() < tot); w++) @(posedge clk);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (oi_q.size() != tot || ni_q.size() != tot) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d/%0d want %0d", name, oi_q.size(), ni_q.size(), tot);
        end
        for (int r = 0; r < tot && r < oi_q.size() && r < ni_q.size(); r++) begin
            f = r / BC;
            m = r % BC;
            for (int j = 0; j < N; j++) begin
                k = m * N + j;
                e_bi[j*DW +: DW] = exp_br(f, k, mode);
                e_bq[j*DW +: DW] = (mode == 2) ? ~exp_br(f, k, mode) : -exp_br(f, k, mode);
                e_ni[j*DW +: DW] = exp_nr(f, k, mode);
                e_nq[j*DW +: DW] = (mode == 2) ? ~exp_nr(f, k, mode) : -exp_nr(f, k, mode);
            end
            n_cmp++;
            if (oc_q[r] != first + r || nc_q[r] != first + r) begin
                n_fail++;
                $display("FAIL %s timing beat %0d: got edge %0d/%0d want %0d", name, r, oc_q[r], nc_q[r], first + r);
            end
            n_cmp++;
            if (os_q[r] !== (m == 0) || oe_q[r] !== (m == BC - 1) ||
                ns_q[r] !== (m == 0) || ne_q[r] !== (m == BC - 1)) begin
                n_fail++;
                $display("FAIL %s sof_eof beat %0d: got %b%b/%b%b want %b%b", name, r,
                         os_q[r], oe_q[r], ns_q[r], ne_q[r], m == 0, m == BC - 1);
            end
            n_cmp++;
            if (oi_q[r] !== e_bi || oq_q[r] !== e_bq) begin
                n_fail++;
                $display("FAIL %s bitrev_data beat %0d: got %h %h want %h %h", name, r, oi_q[r], oq_q[r], e_bi, e_bq);
            end
            n_cmp++;
            if (ni_q[r] !== e_ni || nq_q[r] !== e_nq) begin
                n_fail++;
                $display("FAIL %s bypass_data beat %0d: got %h %h want %h %h", name, r, ni_q[r], nq_q[r], e_ni, e_nq);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || nr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_idle: got %b/%b want 0", name, busy, nr_busy);
        end
    endtask

    // Full frame plus 20 beats of the next, reset while frame 0 is streaming out.
    task automatic test_reset_midframe();
        logic [PW-1:0] vi, vq;
        for (int b = 0; b < BC + 20; b++) begin
            for (int l = 0; l < N; l++) begin
                vi[l*DW +: DW] = in_i(b / BC, (b % BC)*N + l, 0);
                vq[l*DW +: DW] = in_q(b / BC, (b % BC)*N + l, 0);
            end
            drive_beat(vi, vq, 1'b1);
        end
        n_cmp++;
        if (valid_out !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_active: got valid %b busy %b want 1 1", valid_out, busy);
        end
        rst = 1'b1;
        valid_in = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, sof_out, eof_out, busy, nr_valid_out, nr_busy} !== 6'b0 ||
            pack(dout_i) !== '0 || pack(dout_q) !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got ctrl %b data %h want 0",
                     {valid_out, sof_out, eof_out, busy, nr_valid_out, nr_busy}, pack(dout_i));
        end
        clear_queues();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        n_cmp++;
        if (oi_q.size() != 0 || ni_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_discard: got %0d/%0d beats busy %b want 0", oi_q.size(), ni_q.size(), busy);
        end
        test_stream("after_reset", 1, 0, 1'b0);
    endtask

    initial begin
        for (int l = 0; l < N; l++) begin
            din_i[l] = '0;
            din_q[l] = '0;
        end
        test_reset();
        test_stream("single", 1, 0, 1'b0);
        test_stream("natural_in", 1, 1, 1'b0);
        test_stream("gapped", 1, 0, 1'b1);
        test_stream("back_to_back", 3, 0, 1'b0);
        test_reset_midframe();
        test_stream("extreme", 1, 2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Final stage after the stage-2 butterfly/CBFP block of the 512-point FFT.
- Accepts the stage-2 output as 16 complex samples per beat, 32 beats per frame, in bit-reversed index order.
- Re-emits each frame in natural frequency order, 16 samples per beat, over 32 consecutive beats.
- Uses a ping-pong pair of 512-entry register banks, so continuous frames stream with no stall.

Parameters:
- DATA_WIDTH, 13, bit width of each real/imag sample (matches stage-2 output).
- N, 16, samples per beat (lanes).
- BLOCK_CNT, 32, beats per frame. N*BLOCK_CNT = 512 = 2^9.
- BITREV_EN, 1, 1 = bit-reverse reorder; 0 = output in arrival order (bypass order, same latency).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- valid_in, input, 1, input beat valid.
- din_i, input, signed DATA_WIDTH x [0:N-1], real samples.
- din_q, input, signed DATA_WIDTH x [0:N-1], imag samples.
- valid_out, output, 1, output beat valid.
- dout_i, output, signed DATA_WIDTH x [0:N-1], real samples, natural order.
- dout_q, output, signed DATA_WIDTH x [0:N-1], imag samples, natural order.
- sof_out, output, 1, high with output beat 0 of a frame.
- eof_out, output, 1, high with output beat 31 of a frame.
- busy, output, 1, high while any bank holds a partial or unread frame.

Behaviour:
- Reset (async, rst=1):
  - valid_out, sof_out, eof_out, busy = 0; dout_i/dout_q = 0.
  - Write counter wcnt = 0, write bank = 0, read state = IDLE.
  - Bank contents are don't-care; both bank-full flags are cleared.
- Write side:
  - On valid_in=1: lane l is stored at bank[wbank] position p = wcnt*16 + l; wcnt increments.
  - valid_in gaps are allowed; wcnt holds during gaps.
  - When wcnt = 31 and valid_in = 1: mark wbank full, toggle wbank, set wcnt = 0.
- Read FSM states:
  - IDLE: if any bank is full, go to READ with rbank = the oldest full bank and rcnt = 0.
  - READ: every cycle drive one registered output beat m = rcnt, then increment rcnt.
    - At rcnt = 31, clear full[rbank].
    - If the other bank is already full (or becomes full that cycle), move directly to READ on it with rcnt = 0 (no bubble). Otherwise go to IDLE.
- Gather mapping (BITREV_EN=1): output lane j of beat m carries natural index k = m*16 + j, taken from position p = bitrev9(k).
  - Equivalently: source beat = {rev4(j), rev5(m)[4]}, source lane = rev5(m)[3:0].
- Gather mapping (BITREV_EN=0): source beat = m, source lane = j.
- Output timing:
  - Outputs are registered.
  - If the other bank is idle, the frame's last input beat captured at edge t produces output beat 0 at edge t+1. Latency = 1 cycle from the final input beat.
  - valid_out stays high for exactly 32 consecutive cycles per frame.
  - sof_out is high on beat 0 only; eof_out on beat 31 only.
- Data: pure permutation. No arithmetic, width change, or saturation; values pass bit-exact.
- Simultaneous events:
  - Writing the last beat into bank A while reading beat 31 of bank B gives back-to-back frames, with no gap in valid_out.
  - A bank being read is never written, because input needs ≥32 cycles to fill the other bank.
- busy = full[0] | full[1] | (wcnt != 0) | (state == READ).
- Reset mid-frame discards all partial and unread data. The next valid_in after reset is beat 0 of a new frame.

Test Plan:
- Single frame, natural-index ramp: drive 32 contiguous beats with din_i lane l of beat b = bitrev9(b*16+l) and din_q = -din_i.
  - Expect valid_out for 32 cycles starting 1 cycle after the last input.
  - dout_i[j] at beat m = m*16+j (values 0..511 in order); dout_q = negated; sof on beat 0, eof on beat 31.
- BITREV_EN=0: input beat b lane l = b*16+l.
  - Expect identical sequence out, 0..511, same latency.
- Gapped input: valid_in toggles 1/0 for 64 cycles with the same ramp.
  - Expect no output until the 32nd valid beat, then 32 contiguous output beats with correct order.
- Three back-to-back frames (96 contiguous input beats), with frame f offset by +f*512 (two's-complement wrap allowed in 13 bits).
  - Expect 96 contiguous valid_out cycles, frames in order, sof/eof at beats 0/31/32/63/64/95.
- Reset at input beat 20, then a full frame.
  - Expect no output for the aborted frame; valid_out, busy, dout = 0 during reset.
  - The next frame is output correctly starting 1 cycle after its 32nd beat.
- Extreme values: lanes at +4095 / -4096.
  - Expect bit-exact passthrough at the permuted positions, with no sign corruption.
